// File: rtl/adc_avg_fifo_pkg.sv
// Shared ADC constants and the SAR/averager FSM state type.
package adc_pkg;

  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_FIFO_DEPTH = 4;

  typedef enum logic {
    sIdle = 1'b0,
    sAcc  = 1'b1
  } adc_state_t;

endpackage

// File: rtl/adc_avg_fifo_if.sv
// Valid/ready stream carrying averaged ADC samples out of the FIFO.
interface adc_avg_fifo_if #(
  parameter int unsigned DATA_W = 12
);

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/adc_avg_fifo_result_fifo.sv
// First-word-fall-through result FIFO; a push when full is accepted only with a same-edge pop.
module adc_result_fifo
  import adc_pkg::*;
#(
  parameter  int unsigned DATA_W = ADC_DATA_W,
  parameter  int unsigned DEPTH  = ADC_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned LW     = AW + 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic [DATA_W-1:0] head
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_avg_fifo.sv
// Block averager for SAR conversions feeding an output FIFO.
// Define ADC_AVG_ROUND_EN for round-half-up averaging with saturation.
module adc_avg_fifo
  import adc_pkg::*;
#(
  parameter  int unsigned DATA_W     = ADC_DATA_W,
  parameter  int unsigned FIFO_DEPTH = ADC_FIFO_DEPTH,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              avg_en,
  input  logic [1:0]        avg_log2,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] result,
  input  logic              ovf_clr,
  output logic [LW-1:0]     fifo_level,
  output logic              ovf,
  adc_avg_fifo_if.master    out
);

  localparam int unsigned SW = DATA_W + 4;

  adc_state_t        state, state_nxt;
  logic              adc_done_q;
  logic [DATA_W+2:0] acc, acc_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [1:0]        n_lat, nlat_nxt;

  logic              capture;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W+2:0] acc_base;
  logic [3:0]        cnt_base;
  logic [3:0]        cnt_inc;
  logic [1:0]        eff_lat;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     shifted;
  logic [DATA_W-1:0] avg;

  assign capture = adc_done && !adc_done_q;
  assign pop     = out.out_valid && out.out_ready;

  // A block starting in sIdle sees an empty accumulator and the live block size,
  // so the first capture and N=1 share the same completion path.
  assign acc_base = (state == sAcc) ? acc   : '0;
  assign cnt_base = (state == sAcc) ? cnt   : '0;
  assign eff_lat  = (state == sAcc) ? n_lat : avg_log2;
  assign sum      = SW'(acc_base) + SW'(result);
  assign cnt_inc  = cnt_base + 4'd1;

`ifdef ADC_AVG_ROUND_EN
  logic [SW-1:0] rnd;
  assign rnd     = (eff_lat == 2'd0) ? '0 : (SW'(1) << (eff_lat - 2'd1));
  assign shifted = (sum + rnd) >> eff_lat;
`else
  assign shifted = sum >> eff_lat;
`endif
  assign avg = (|shifted[SW-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= sIdle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    nlat_nxt  = n_lat;
    push      = 1'b0;
    if (!avg_en) begin
      if (state == sAcc) begin
        state_nxt = sIdle;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
    end else if (capture) begin
      acc_nxt = sum[DATA_W+2:0];
      cnt_nxt = cnt_inc;
      if (state == sIdle) nlat_nxt = avg_log2;
      if (cnt_inc == (4'd1 << eff_lat)) begin
        push      = 1'b1;
        state_nxt = sIdle;
      end else begin
        state_nxt = sAcc;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      adc_done_q <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      n_lat      <= '0;
      ovf        <= 1'b0;
    end else begin
      adc_done_q <= adc_done;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      n_lat      <= nlat_nxt;
      if (push && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  adc_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clkin     (clkin),
    .rst       (rst),
    .push      (push),
    .push_data (avg),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level),
    .head      (out.out_data)
  );

  assign out.out_valid = !empty;

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed bench for adc_avg_fifo; set ADC_AVG_ROUND_EN to match the RTL build.
module tb_adc_avg_fifo;

  localparam int unsigned DW = 12;

`ifdef ADC_AVG_ROUND_EN
  localparam logic [31:0] EXP_T2 = 32'd12;
`else
  localparam logic [31:0] EXP_T2 = 32'd11;
`endif

  logic          clkin    = 1'b0;
  logic          rst      = 1'b1;
  logic          avg_en   = 1'b0;
  logic [1:0]    avg_log2 = 2'd0;
  logic          adc_done = 1'b0;
  logic [DW-1:0] result   = '0;
  logic          ovf_clr  = 1'b0;
  logic [2:0]    fifo_level;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  adc_avg_fifo_if #(.DATA_W(DW)) ofs ();

  adc_avg_fifo #(
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .avg_en     (avg_en),
    .avg_log2   (avg_log2),
    .adc_done   (adc_done),
    .result     (result),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .out        (ofs)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic [DW-1:0] v);
    result   = v;
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    check(tag, ofs.out_data, exp);
    ofs.out_ready = 1'b1;
    tick();
    ofs.out_ready = 1'b0;
  endtask

  initial begin
    ofs.out_ready = 1'b0;

    // reset state
    #12;
    check("rst valid", ofs.out_valid, 0);
    check("rst data", ofs.out_data, 0);
    check("rst level", fifo_level, 0);
    check("rst ovf", ovf, 0);
    rst = 1'b0;
    tick();
    avg_en = 1'b1;

    // N=1 pass-through with one-cycle latency
    avg_log2 = 2'd0;
    result = 12'd100; adc_done = 1'b1; tick();
    check("t1 valid", ofs.out_valid, 1);
    check("t1 data0", ofs.out_data, 100);
    adc_done = 1'b0; tick();
    result = 12'd4095; adc_done = 1'b1; tick();
    check("t1 level2", fifo_level, 2);
    adc_done = 1'b0; tick();
    pop_chk("t1 pop0", 100);
    pop_chk("t1 pop1", 4095);
    check("t1 empty", ofs.out_valid, 0);

    // N=4 block, block size change mid-block ignored
    avg_log2 = 2'd2;
    cap(12'd10);
    avg_log2 = 2'd3;
    cap(12'd11);
    cap(12'd12);
    check("t2 partial", fifo_level, 0);
    cap(12'd14);
    check("t2 level", fifo_level, 1);
    pop_chk("t2 avg", EXP_T2);
    check("t2 empty", fifo_level, 0);

    // overflow, set-wins-over-clear, clear, ordered drain
    avg_log2 = 2'd0;
    for (int i = 0; i < 4; i++) cap(12'(21 + i));
    check("t3 full", fifo_level, 4);
    check("t3 noovf", ovf, 0);
    cap(12'd25);
    check("t3 drop level", fifo_level, 4);
    check("t3 ovf", ovf, 1);
    result = 12'd26; adc_done = 1'b1; ovf_clr = 1'b1; tick();
    check("t3 set wins", ovf, 1);
    ovf_clr = 1'b0; adc_done = 1'b0; tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t3 cleared", ovf, 0);
    for (int i = 0; i < 4; i++) pop_chk("t3 pop", 32'(21 + i));
    check("t3 empty", fifo_level, 0);

    // push and pop on the same edge while full
    for (int i = 0; i < 4; i++) cap(12'(31 + i));
    result = 12'd35; adc_done = 1'b1; ofs.out_ready = 1'b1; tick();
    check("t4 level", fifo_level, 4);
    check("t4 ovf", ovf, 0);
    ofs.out_ready = 1'b0; adc_done = 1'b0; tick();
    for (int i = 0; i < 4; i++) pop_chk("t4 pop", 32'(32 + i));
    check("t4 empty", fifo_level, 0);

    // held done level counts once
    avg_log2 = 2'd2;
    result = 12'd40; adc_done = 1'b1; tick(); tick(); tick();
    adc_done = 1'b0; tick();
    check("t5 held", fifo_level, 0);
    cap(12'd40);
    cap(12'd40);
    check("t5 three", fifo_level, 0);
    cap(12'd40);
    check("t5 done", fifo_level, 1);
    pop_chk("t5 avg", 40);

    // abort partial block, captures ignored while disabled
    cap(12'd50);
    cap(12'd60);
    avg_en = 1'b0; tick();
    cap(12'd99);
    avg_en = 1'b1;
    for (int i = 0; i < 3; i++) cap(12'd8);
    check("t5 abort partial", fifo_level, 0);
    cap(12'd8);
    check("t5 abort level", fifo_level, 1);
    pop_chk("t5 abort avg", 8);

    // reset mid-block with stored entries
    avg_log2 = 2'd0;
    cap(12'd70);
    cap(12'd71);
    check("t6 stored", fifo_level, 2);
    avg_log2 = 2'd2;
    cap(12'd1); cap(12'd2); cap(12'd3);
    rst = 1'b1; #1;
    check("t6 rst valid", ofs.out_valid, 0);
    check("t6 rst data", ofs.out_data, 0);
    check("t6 rst level", fifo_level, 0);
    check("t6 rst ovf", ovf, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) cap(12'd20);
    check("t6 partial", fifo_level, 0);
    cap(12'd20);
    check("t6 level", fifo_level, 1);
    pop_chk("t6 avg", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
